knn_vote: RTL

Majority-vote classifier at the read end of the KNN sorter. After the sorter finishes a pass, this block walks the sorted neighbour slots through the sorter's select port, nearest first. For each slot it reads the stored index, looks up the training label in an external label memory, accumulates per-class votes and scans them for the winner. It sits between the KNN sorter and the peripheral register file, which reads `class_out`/`win_cnt` after `done`.

---
 rtl/knn_vote.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/knn_vote.sv
// knn_vote: majority-vote classifier that walks the sorted KNN neighbour
// slots nearest first, looks up each neighbour's training label, counts
// votes per class and scans for the winner. Ties with the nearest
// neighbour's class keep that class; other ties go to the lowest class index.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE.
// Labels are read with lbl_rd/lbl_addr, and lbl_data is valid exactly one
// cycle later. done is a one-cycle pulse. class_out and win_cnt are valid
// from that pulse and are held until the next done.
module knn_vote #(
    parameter int K     = 4,
    parameter int IDX_W = 8,
    parameter int C_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(K+1)-1:0]   k_used,
    output logic [$clog2(K)-1:0]     sel,
    input  logic [IDX_W-1:0]         idx_in,
    output logic                     lbl_rd,
    output logic [IDX_W-1:0]         lbl_addr,
    input  logic [C_W-1:0]           lbl_data,
    output logic                     busy,
    output logic                     done,
    output logic [C_W-1:0]           class_out,
    output logic [$clog2(K+1)-1:0]   win_cnt
);

    localparam int KW = $clog2(K + 1);
    localparam int SW = $clog2(K);
    localparam int NC = 1 << C_W;
    localparam logic [KW-1:0] K_MAX = KW'(K);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, SCAN, DONE} state_t;

    state_t         state;
    state_t         state_next;

    logic [KW-1:0]  k_lat;
    logic [KW-1:0]  rd_cnt;
    logic           rd_q;       // a label is returning this cycle
    logic           first_q;    // ...and it belongs to slot 0
    logic [C_W-1:0] near_cls;
    logic [KW-1:0]  votes [NC];

    logic [C_W-1:0] scan_c;
    logic [C_W-1:0] best_cls;
    logic [KW-1:0]  best_cnt;
    logic [C_W-1:0] cur_cls;
    logic [KW-1:0]  cur_cnt;
    logic [C_W-1:0] nb_cls;
    logic [KW-1:0]  nb_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and the per-state sorter/label-memory strobes.
    always_comb begin
        state_next = state;
        sel        = '0;
        lbl_rd     = 1'b0;
        lbl_addr   = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = READ;
            end
            READ: begin
                sel      = rd_cnt[SW-1:0];
                lbl_rd   = 1'b1;
                lbl_addr = idx_in;
                if (rd_cnt == k_lat - KW'(1)) state_next = DRAIN;
            end
            DRAIN: state_next = SCAN;
            SCAN: begin
                if (scan_c == C_W'(NC - 1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One scan step. The first step seeds the running best with the nearest
    // neighbour's class, so that only a strictly larger count displaces it.
    always_comb begin
        cur_cls = best_cls;
        cur_cnt = best_cnt;
        if (scan_c == '0) begin
            cur_cls = near_cls;
            cur_cnt = votes[near_cls];
        end
        nb_cls = cur_cls;
        nb_cnt = cur_cnt;
        if (votes[scan_c] > cur_cnt) begin
            nb_cls = scan_c;
            nb_cnt = votes[scan_c];
        end
    end

    // Datapath: request latch, read counter, vote pipeline, scan and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_lat     <= '0;
            rd_cnt    <= '0;
            rd_q      <= 1'b0;
            first_q   <= 1'b0;
            near_cls  <= '0;
            scan_c    <= '0;
            best_cls  <= '0;
            best_cnt  <= '0;
            class_out <= '0;
            win_cnt   <= '0;
            for (int i = 0; i < NC; i++) votes[i] <= '0;
        end else begin
            rd_q    <= lbl_rd;
            first_q <= lbl_rd && (rd_cnt == '0);
            if (state == IDLE && start) begin
                k_lat  <= (k_used == '0 || k_used > K_MAX) ? K_MAX : k_used;
                rd_cnt <= '0;
                scan_c <= '0;
                for (int i = 0; i < NC; i++) votes[i] <= '0;
            end
            if (state == READ) rd_cnt <= rd_cnt + KW'(1);
            if (rd_q) begin
                votes[lbl_data] <= votes[lbl_data] + KW'(1);
                if (first_q) near_cls <= lbl_data;
            end
            if (state == SCAN) begin
                scan_c   <= scan_c + C_W'(1);
                best_cls <= nb_cls;
                best_cnt <= nb_cnt;
                if (scan_c == C_W'(NC - 1)) begin
                    class_out <= nb_cls;
                    win_cnt   <= nb_cnt;
                end
            end
        end
    end

endmodule
